// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) single-outstanding memory arbiter.
//
// Purpose
//   Arbitrates a fetch port (i_*) and a data port (d_*) onto one memory port
//   (mem_*) with a fixed-latency read return. One transaction is in flight at
//   a time and moves through IDLE -> ISSUE -> WAIT -> DONE.
//   Grants are combinational and are only given in IDLE. The data port wins
//   over the fetch port.
//
// Ports
//   clock, reset           - rising-edge clock, async active-low reset
//   i_req/i_addr           - fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata - fetch grant, completion pulse, read data
//   d_req/d_addr/d_wdata/d_rw/d_size - data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata - data grant, completion pulse, load data
//   mem_en/mem_addr/mem_wdata/mem_rw/mem_size/mem_rdata - memory port
//   busy                   - FSM not in IDLE
//
// Configuration
//   ARB_FAIRNESS_EN - when defined, after STARVE_MAX consecutive data grants
//                     made while i_req is pending, the next arbitration goes
//                     to the fetch port.
module mem_arbiter #(
  parameter int unsigned DATAW      = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_req,
  input  logic [DATAW-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [DATAW-1:0] i_rdata,
  input  logic             d_req,
  input  logic [DATAW-1:0] d_addr,
  input  logic [DATAW-1:0] d_wdata,
  input  logic             d_rw,
  input  logic [1:0]       d_size,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DATAW-1:0] d_rdata,
  output logic             mem_en,
  output logic [DATAW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  output logic             mem_rw,
  output logic [1:0]       mem_size,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // WAIT lasts MEM_LAT cycles; the counter runs 0..MEM_LAT-1 and the data is
  // captured on its terminal value (MEM_LAT cycles after the mem_en cycle).
  localparam logic [3:0] CntLast = 4'(MEM_LAT - 1);

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic             r_is_data;
  logic [DATAW-1:0] r_addr;
  logic [DATAW-1:0] r_wdata;
  logic             r_rw;
  logic [1:0]       r_size;
  logic             r_mem_en;
  logic             r_i_rvalid;
  logic             r_d_rvalid;
  logic [DATAW-1:0] r_i_rdata;
  logic [DATAW-1:0] r_d_rdata;
  logic             r_busy;

  logic             w_pick_d;
  logic             w_pick_i;
  logic             w_force_i;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [StarveW-1:0] r_starve;

  assign w_force_i = i_req && (r_starve == StarveW'(STARVE_MAX));

  // Counts data grants that bypassed a waiting fetch; any fetch grant or an
  // idle cycle without a fetch request restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (r_state == StIdle) begin
      if (w_pick_i || !i_req) begin
        r_starve <= '0;
      end else if (w_pick_d) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  // Reset gating keeps grants low while reset holds the FSM in IDLE.
  always_comb begin
    w_pick_d = 1'b0;
    w_pick_i = 1'b0;
    if (reset && (r_state == StIdle)) begin
      if (d_req && !w_force_i) begin
        w_pick_d = 1'b1;
      end else if (i_req) begin
        w_pick_i = 1'b1;
      end
    end
  end

  assign i_gnt = w_pick_i;
  assign d_gnt = w_pick_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_is_data  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rw       <= 1'b0;
      r_size     <= '0;
      r_mem_en   <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_en   <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pick_d) begin
            r_addr    <= d_addr;
            r_wdata   <= d_wdata;
            r_rw      <= d_rw;
            r_size    <= d_size;
            r_is_data <= 1'b1;
            r_mem_en  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StIssue;
          end else if (w_pick_i) begin
            r_addr    <= i_addr;
            r_wdata   <= '0;
            r_rw      <= 1'b0;
            r_size    <= 2'b10;
            r_is_data <= 1'b0;
            r_mem_en  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (r_cnt == CntLast) begin
            r_state <= StDone;
            if (r_is_data) begin
              r_d_rvalid <= 1'b1;
              // Writes complete without disturbing the last load data.
              if (!r_rw) begin
                r_d_rdata <= mem_rdata;
              end
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rw    = r_rw;
  assign mem_size  = r_size;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// u_dut uses default parameters; u_dut1 uses MEM_LAT=1 for the short-latency
// fetch cadence. Fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_arbiter;
  localparam int unsigned W = 32;

  logic         clock;
  logic         reset;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_gnt;
  logic         i_rvalid;
  logic [W-1:0] i_rdata;
  logic         d_req;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_rw;
  logic [1:0]   d_size;
  logic         d_gnt;
  logic         d_rvalid;
  logic [W-1:0] d_rdata;
  logic         mem_en;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_rw;
  logic [1:0]   mem_size;
  logic [W-1:0] mem_rdata;
  logic         busy;

  logic         f_i_req;
  logic [W-1:0] f_i_addr;
  logic         f_i_gnt;
  logic         f_i_rvalid;
  logic [W-1:0] f_i_rdata;
  logic         f_d_req;
  logic [W-1:0] f_d_addr;
  logic [W-1:0] f_d_wdata;
  logic         f_d_rw;
  logic [1:0]   f_d_size;
  logic         f_d_gnt;
  logic         f_d_rvalid;
  logic [W-1:0] f_d_rdata;
  logic         f_mem_en;
  logic [W-1:0] f_mem_addr;
  logic [W-1:0] f_mem_wdata;
  logic         f_mem_rw;
  logic [1:0]   f_mem_size;
  logic [W-1:0] f_mem_rdata;
  logic         f_busy;

  int n_tests;
  int n_fail;

  mem_arbiter #(.DATAW(W), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rw     (d_rw),
    .d_size   (d_size),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rw   (mem_rw),
    .mem_size (mem_size),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  mem_arbiter #(.DATAW(W), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clock    (clock),
    .reset    (reset),
    .i_req    (f_i_req),
    .i_addr   (f_i_addr),
    .i_gnt    (f_i_gnt),
    .i_rvalid (f_i_rvalid),
    .i_rdata  (f_i_rdata),
    .d_req    (f_d_req),
    .d_addr   (f_d_addr),
    .d_wdata  (f_d_wdata),
    .d_rw     (f_d_rw),
    .d_size   (f_d_size),
    .d_gnt    (f_d_gnt),
    .d_rvalid (f_d_rvalid),
    .d_rdata  (f_d_rdata),
    .mem_en   (f_mem_en),
    .mem_addr (f_mem_addr),
    .mem_wdata(f_mem_wdata),
    .mem_rw   (f_mem_rw),
    .mem_size (f_mem_size),
    .mem_rdata(f_mem_rdata),
    .busy     (f_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [5:0] seq;
  logic [5:0] exp_seq;
  int         ng;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    i_req = 1'b1; i_addr = '0;
    d_req = 1'b1; d_addr = '0; d_wdata = '0; d_rw = 1'b0; d_size = 2'b00;
    mem_rdata = '0;
    f_i_req = 1'b0; f_i_addr = 32'h0100_0000;
    f_d_req = 1'b0; f_d_addr = '0; f_d_wdata = '0; f_d_rw = 1'b0; f_d_size = 2'b00;
    f_mem_rdata = '0;
    #1 reset = 1'b0;

    // Reset state, with both requests raised to show grants stay low.
    tick(); tick(); #1;
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_i_rvalid", i_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    reset = 1'b1;

    // Fetch read, MEM_LAT=2.
    tick();
    i_req = 1'b1; i_addr = 32'h0100_0000; mem_rdata = 32'h0000_0013;
    #1;
    chk1("a_c0_i_gnt", i_gnt, 1'b1);
    chk1("a_c0_d_gnt", d_gnt, 1'b0);
    tick(); i_req = 1'b0; #1;
    chk1("a_c1_mem_en", mem_en, 1'b1);
    chk32("a_c1_mem_addr", mem_addr, 32'h0100_0000);
    chk1("a_c1_mem_rw", mem_rw, 1'b0);
    chk32("a_c1_mem_size", 32'(mem_size), 32'h2);
    chk1("a_c1_busy", busy, 1'b1);
    tick(); #1;
    chk1("a_c2_mem_en", mem_en, 1'b0);
    tick(); #1;
    chk1("a_c3_i_rvalid", i_rvalid, 1'b0);
    tick(); #1;
    chk1("a_c4_i_rvalid", i_rvalid, 1'b1);
    chk32("a_c4_i_rdata", i_rdata, 32'h0000_0013);
    tick(); #1;
    chk1("a_c5_busy", busy, 1'b0);
    chk1("a_c5_i_rvalid", i_rvalid, 1'b0);
    chk32("a_c5_i_rdata_hold", i_rdata, 32'h0000_0013);

    // Simultaneous requests: data wins, fetch stays pending.
    tick();
    i_req = 1'b1; i_addr = 32'h0100_0004;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0100_0100; d_size = 2'b10;
    mem_rdata = 32'h0000_00AA;
    #1;
    chk1("b_c0_d_gnt", d_gnt, 1'b1);
    chk1("b_c0_i_gnt", i_gnt, 1'b0);
    tick(); d_req = 1'b0; #1;
    chk32("b_c1_mem_addr", mem_addr, 32'h0100_0100);
    chk1("b_c1_i_gnt", i_gnt, 1'b0);
    tick(); tick(); tick(); #1;
    chk1("b_c4_d_rvalid", d_rvalid, 1'b1);
    chk32("b_c4_d_rdata", d_rdata, 32'h0000_00AA);
    chk1("b_c4_i_rvalid", i_rvalid, 1'b0);
    mem_rdata = 32'h0000_00BB;
    tick(); #1;
    chk1("b_c5_i_gnt", i_gnt, 1'b1);
    tick(); i_req = 1'b0; #1;
    chk32("b_c6_mem_addr", mem_addr, 32'h0100_0004);
    tick(); tick(); tick(); #1;
    chk1("b_c9_i_rvalid", i_rvalid, 1'b1);
    chk32("b_c9_i_rdata", i_rdata, 32'h0000_00BB);
    chk1("b_c9_d_rvalid", d_rvalid, 1'b0);
    chk32("b_c9_d_rdata_hold", d_rdata, 32'h0000_00AA);
    tick(); #1;
    chk1("b_c10_busy", busy, 1'b0);

    // Data write: d_rdata must keep the last load value.
    tick();
    d_req = 1'b1; d_rw = 1'b1; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h0000_2000;
    d_size = 2'b10; mem_rdata = 32'h5555_5555;
    #1;
    chk1("c_c0_d_gnt", d_gnt, 1'b1);
    tick(); d_req = 1'b0; d_rw = 1'b0; #1;
    chk1("c_c1_mem_en", mem_en, 1'b1);
    chk1("c_c1_mem_rw", mem_rw, 1'b1);
    chk32("c_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk32("c_c1_mem_size", 32'(mem_size), 32'h2);
    tick(); #1;
    chk1("c_c2_mem_en", mem_en, 1'b0);
    tick(); tick(); #1;
    chk1("c_c4_d_rvalid", d_rvalid, 1'b1);
    chk32("c_c4_d_rdata", d_rdata, 32'h0000_00AA);
    tick(); #1;
    chk1("c_c5_busy", busy, 1'b0);

    // Both requests held: grant order depends on fairness build.
`ifdef ARB_FAIRNESS_EN
    exp_seq = 6'b101111;
`else
    exp_seq = 6'b111111;
`endif
    seq = '0;
    ng  = 0;
    tick();
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0000_4000;
    i_req = 1'b1; i_addr = 32'h0000_5000;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      if (c > 0) tick();
      #1;
      if (d_gnt || i_gnt) begin
        seq[ng] = d_gnt;
        ng++;
      end
    end
    chk32("d_ngrants", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("d_grant%0d_is_data", k), seq[k], exp_seq[k]);
    end
    tick();
    d_req = 1'b0; i_req = 1'b0;
    repeat (6) tick();
    #1;
    chk1("d_idle_busy", busy, 1'b0);

    // Reset during WAIT aborts without a completion pulse.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_3000; mem_rdata = 32'h0000_0066;
    #1;
    chk1("e_c0_i_gnt", i_gnt, 1'b1);
    tick(); i_req = 1'b0; #1;
    tick(); #1;
    chk1("e_c2_busy", busy, 1'b1);
    reset = 1'b0;
    i_req = 1'b1;
    #1;
    chk1("e_rst_mem_en", mem_en, 1'b0);
    chk1("e_rst_busy", busy, 1'b0);
    chk1("e_rst_i_rvalid", i_rvalid, 1'b0);
    chk32("e_rst_i_rdata", i_rdata, 32'h0);
    chk32("e_rst_d_rdata", d_rdata, 32'h0);
    chk32("e_rst_mem_addr", mem_addr, 32'h0);
    chk1("e_rst_i_gnt", i_gnt, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk1($sformatf("e_rst_hold%0d_i_rvalid", c), i_rvalid, 1'b0);
    end
    tick();
    reset = 1'b1;
    #1;
    chk1("e_rel_i_gnt", i_gnt, 1'b1);
    tick(); i_req = 1'b0; #1;
    chk1("e_rel_mem_en", mem_en, 1'b1);
    chk32("e_rel_mem_addr", mem_addr, 32'h0000_3000);
    tick(); tick(); tick(); #1;
    chk1("e_rel_i_rvalid", i_rvalid, 1'b1);
    chk32("e_rel_i_rdata", i_rdata, 32'h0000_0066);

    // MEM_LAT=1: grant every 4 cycles, rvalid 3 cycles after each grant.
    tick();
    f_i_req = 1'b1; f_mem_rdata = 32'h0000_0099;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) tick();
      #1;
      chk1($sformatf("f_c%0d_i_gnt", c), f_i_gnt, (c % 4) == 0);
      chk1($sformatf("f_c%0d_i_rvalid", c), f_i_rvalid, (c % 4) == 3);
      if ((c % 4) == 3) begin
        chk32($sformatf("f_c%0d_i_rdata", c), f_i_rdata, 32'h0000_0099);
      end
    end
    tick();
    f_i_req = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
